// File: rtl/intra_nb_ctx.sv
// intra_nb_ctx: neighbour-context stage feeding the intra-16x16 mode picker.
//
// For each macroblock request it presents the top row, left column and corner
// pixel, substituting the VP8 edge defaults (0x7F above, 0x81 to the left)
// where a neighbour is unavailable. On each reconstruction update it stores
// the MB's bottom row in a line buffer and its right column in a left register.
//
// Optional feature: define NB_SEQ_CHECK_EN to track the last acked request
// and flag out-of-order request/update sequences on seq_err.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   frame_start      one-cycle pulse, clears per-frame context and error flags
//   req/req_x/req_y  context request (level, held until ack)
//   ack              one-cycle pulse, top/left/top_left valid from here on
//   top, left        16-pixel neighbour row/column, pixel 0 in bits [7:0]
//   top_left         corner pixel
//   upd/upd_x/upd_y  reconstruction update (level, held until upd_ack)
//   rec              reconstructed MB, raster order, byte r*16+c
//   upd_ack          one-cycle pulse, update committed
//   busy             high whenever the FSM is not idle
//   err_oob          sticky, an MB column >= MAX_MB_W was seen
//   seq_err          sticky sequence error (0 unless NB_SEQ_CHECK_EN)
module intra_nb_ctx #(
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned MAX_MB_W   = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_start,
  input  logic                               req,
  input  logic [9:0]                         req_x,
  input  logic [9:0]                         req_y,
  output logic                               ack,
  output logic [8*BLOCK_SIZE-1:0]            top,
  output logic [8*BLOCK_SIZE-1:0]            left,
  output logic [7:0]                         top_left,
  input  logic                               upd,
  input  logic [9:0]                         upd_x,
  input  logic [9:0]                         upd_y,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] rec,
  output logic                               upd_ack,
  output logic                               busy,
  output logic                               err_oob,
  output logic                               seq_err
);

  localparam int unsigned RowW = 8 * BLOCK_SIZE;
  localparam int unsigned AW   = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;
  localparam logic [RowW-1:0] TopDefault  = {BLOCK_SIZE{8'h7f}};
  localparam logic [RowW-1:0] LeftDefault = {BLOCK_SIZE{8'h81}};

  typedef enum logic [1:0] {StIdle, StRd, StRsp, StWr} state_e;

  state_e          state_q, state_d;
  logic [9:0]      x_q, y_q;
  logic [RowW-1:0] top_q, left_q, left_reg_q;
  logic [7:0]      top_left_q, tl_reg_q;
  logic            err_oob_q;
  logic [RowW-1:0] lb_mem [MAX_MB_W];
  logic [RowW-1:0] lb_rd_q;
  logic [RowW-1:0] rec_row, rec_col;
  logic            req_oob, upd_oob, lb_rd_en, lb_wr_en;

  // Bottom row and right column of the reconstructed MB.
  always_comb begin
    rec_row = rec[RowW*(BLOCK_SIZE-1) +: RowW];
    rec_col = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      rec_col[8*r +: 8] = rec[8*(r*BLOCK_SIZE + BLOCK_SIZE - 1) +: 8];
    end
  end

  assign req_oob  = (32'(x_q) >= MAX_MB_W);
  assign upd_oob  = (32'(upd_x) >= MAX_MB_W);
  assign lb_rd_en = (state_q == StIdle) && !frame_start && !upd && req;
  assign lb_wr_en = (state_q == StWr) && !frame_start && !upd_oob;

  // Line buffer: no reset, rows are always written before being read in a frame.
  always_ff @(posedge clk) begin
    if (lb_wr_en) lb_mem[upd_x[AW-1:0]] <= rec_row;
    if (lb_rd_en) lb_rd_q <= lb_mem[req_x[AW-1:0]];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; updates win over requests in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (upd)      state_d = StWr;
        else if (req) state_d = StRd;
      end
      StRd:    state_d = StRsp;
      StRsp:   state_d = StIdle;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (frame_start) state_d = StIdle;
  end

  // Outputs; frame_start squashes an ack that would otherwise show this cycle.
  always_comb begin
    ack     = (state_q == StRsp) && !frame_start;
    upd_ack = (state_q == StWr) && !frame_start;
    busy    = (state_q != StIdle);
  end

  // Context datapath. Outputs are loaded leaving RD so they are valid with ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      top_q      <= '0;
      left_q     <= '0;
      top_left_q <= '0;
      left_reg_q <= '0;
      tl_reg_q   <= '0;
      err_oob_q  <= 1'b0;
    end else if (frame_start) begin
      left_reg_q <= '0;
      tl_reg_q   <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lb_rd_en) begin
            x_q <= req_x;
            y_q <= req_y;
          end
        end
        StRd: begin
          top_q  <= (y_q == '0 || req_oob) ? TopDefault : lb_rd_q;
          left_q <= (x_q == '0) ? LeftDefault : left_reg_q;
          if (y_q == '0)      top_left_q <= 8'h7f;
          else if (x_q == '0) top_left_q <= 8'h81;
          else                top_left_q <= tl_reg_q;
          if (req_oob) err_oob_q <= 1'b1;
        end
        StWr: begin
          left_reg_q <= rec_col;
          // Current top pixel 15 becomes the corner for the MB to the right.
          tl_reg_q   <= top_q[RowW-1 -: 8];
          if (upd_oob) err_oob_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign top      = top_q;
  assign left     = left_q;
  assign top_left = top_left_q;
  assign err_oob  = err_oob_q;

`ifdef NB_SEQ_CHECK_EN
  logic [9:0] last_x_q, last_y_q;
  logic       have_req_q, pend_q, seq_err_q;

  // pend_q: a request has been acked and no update has followed yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_x_q   <= '0;
      last_y_q   <= '0;
      have_req_q <= 1'b0;
      pend_q     <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (frame_start) begin
      have_req_q <= 1'b0;
      pend_q     <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (state_q == StRsp) begin
      if (pend_q) seq_err_q <= 1'b1;
      last_x_q   <= x_q;
      last_y_q   <= y_q;
      have_req_q <= 1'b1;
      pend_q     <= 1'b1;
    end else if (state_q == StWr) begin
      if (have_req_q && (upd_x != last_x_q || upd_y != last_y_q)) seq_err_q <= 1'b1;
      pend_q <= 1'b0;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_upd_y;
  assign unused_upd_y = ^upd_y;
  assign seq_err      = 1'b0;
`endif

endmodule

// File: tb/tb_intra_nb_ctx.sv
// Directed self-checking bench for intra_nb_ctx.
module tb_intra_nb_ctx;

`ifdef NB_SEQ_CHECK_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, frame_start, req, upd;
  logic [9:0]    req_x, req_y, upd_x, upd_y;
  logic          ack, upd_ack, busy, err_oob, seq_err;
  logic [127:0]  top, left;
  logic [7:0]    top_left;
  logic [2047:0] rec;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [127:0] cap_top, cap_left;
  logic [7:0]   cap_tl;

  always #5 clk = ~clk;

  intra_nb_ctx #(
    .BLOCK_SIZE(16),
    .MAX_MB_W  (128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .ack        (ack),
    .top        (top),
    .left       (left),
    .top_left   (top_left),
    .upd        (upd),
    .upd_x      (upd_x),
    .upd_y      (upd_y),
    .rec        (rec),
    .upd_ack    (upd_ack),
    .busy       (busy),
    .err_oob    (err_oob),
    .seq_err    (seq_err)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  // Row with byte c = base + c.
  function automatic logic [127:0] row_of(input logic [7:0] base);
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[8*c +: 8] = base + 8'(c);
    return r;
  endfunction

  // Every row identical: pixel (r,c) = base + c.
  function automatic logic [2047:0] mk_rec_row(input logic [7:0] base);
    logic [2047:0] m;
    for (int r = 0; r < 16; r++) m[128*r +: 128] = row_of(base);
    return m;
  endfunction

  // pixel (r,c) = r*16 + c
  function automatic logic [2047:0] mk_rec_rc();
    logic [2047:0] m;
    for (int i = 0; i < 256; i++) m[8*i +: 8] = 8'(i);
    return m;
  endfunction

  task automatic wait_ack(output int n);
    n = 0;
    while (ack !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (ack !== 1'b1) n = -1;
    cap_top  = top;
    cap_left = left;
    cap_tl   = top_left;
  endtask

  task automatic wait_upd_ack(output int n);
    n = 0;
    while (upd_ack !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (upd_ack !== 1'b1) n = -1;
  endtask

  task automatic do_req(input logic [9:0] x, input logic [9:0] y, output int n);
    req_x = x;
    req_y = y;
    req   = 1'b1;
    wait_ack(n);
    req = 1'b0;
    step();
  endtask

  task automatic do_upd(input logic [9:0] x, input logic [9:0] y, input logic [2047:0] d,
                        output int n);
    upd_x = x;
    upd_y = y;
    rec   = d;
    upd   = 1'b1;
    wait_upd_ack(n);
    upd = 1'b0;
    step();
  endtask

  initial begin
    logic [127:0] exp_col;
    rst_n = 1'b0; frame_start = 1'b0; req = 1'b0; upd = 1'b0;
    req_x = '0; req_y = '0; upd_x = '0; upd_y = '0; rec = '0;
    repeat (3) step();
    check_eq("rst_ack", 128'(ack), 128'(0));
    check_eq("rst_upd_ack", 128'(upd_ack), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_top", top, 128'(0));
    check_eq("rst_left", left, 128'(0));
    check_eq("rst_tl", 128'(top_left), 128'(0));
    check_eq("rst_oob", 128'(err_oob), 128'(0));
    check_eq("rst_seq", 128'(seq_err), 128'(0));
    rst_n = 1'b1;
    step();
    pulse_fs();

    // Corner MB
    do_req(0, 0, lat);
    check_eq("c00_lat", 128'(lat), 128'(2));
    check_eq("c00_top", cap_top, fill(8'h7f));
    check_eq("c00_left", cap_left, fill(8'h81));
    check_eq("c00_tl", 128'(cap_tl), 128'(8'h7f));

    // Left register from column 15
    do_upd(0, 0, mk_rec_rc(), lat);
    check_eq("u00_lat", 128'(lat), 128'(1));
    do_req(1, 0, lat);
    for (int r = 0; r < 16; r++) exp_col[8*r +: 8] = 8'(r*16 + 15);
    check_eq("c10_left", cap_left, exp_col);
    check_eq("c10_top", cap_top, fill(8'h7f));
    check_eq("c10_tl", 128'(cap_tl), 128'(8'h7f));

    // Line buffer and corner
    pulse_fs();
    for (int x = 0; x < 3; x++) begin
      do_req(10'(x), 0, lat);
      do_upd(10'(x), 0, mk_rec_row(8'(16*x)), lat);
    end
    do_req(0, 1, lat);
    check_eq("c01_top", cap_top, row_of(8'h00));
    check_eq("c01_left", cap_left, fill(8'h81));
    check_eq("c01_tl", 128'(cap_tl), 128'(8'h81));
    do_upd(0, 1, mk_rec_row(8'h50), lat);
    do_req(1, 1, lat);
    check_eq("c11_tl", 128'(cap_tl), 128'(8'h0f));
    check_eq("c11_top", cap_top, row_of(8'h10));
    check_eq("c11_left", cap_left, fill(8'h5f));

    // Priority: upd and req together
    rec = mk_rec_row(8'h60); upd_x = 1; upd_y = 1; upd = 1'b1;
    req_x = 1; req_y = 2; req = 1'b1;
    wait_upd_ack(lat);
    check_eq("pri_upd_lat", 128'(lat), 128'(1));
    upd = 1'b0;
    wait_ack(lat);
    check_eq("pri_req_lat", 128'(lat), 128'(3));
    req = 1'b0;
    step();
    check_eq("pri_top", cap_top, row_of(8'h60));
    check_eq("pri_left", cap_left, fill(8'h6f));
    check_eq("pri_tl", 128'(cap_tl), 128'(8'h1f));

    // Abort in RD
    req_x = 2; req_y = 2; req = 1'b1;
    step();
    check_eq("abt_busy_rd", 128'(busy), 128'(1));
    frame_start = 1'b1; req = 1'b0;
    step();
    frame_start = 1'b0;
    check_eq("abt_busy", 128'(busy), 128'(0));
    check_eq("abt_ack", 128'(ack), 128'(0));
    step();
    check_eq("abt_ack2", 128'(ack), 128'(0));

    // Out-of-range update leaves line buffer entry 72 (200 mod 128) intact
    do_upd(72, 0, mk_rec_row(8'h70), lat);
    check_eq("oob_pre", 128'(err_oob), 128'(0));
    do_upd(200, 0, mk_rec_row(8'h90), lat);
    check_eq("oob_upd_lat", 128'(lat), 128'(1));
    check_eq("oob_upd_err", 128'(err_oob), 128'(1));
    do_req(72, 1, lat);
    check_eq("oob_lb_keep", cap_top, row_of(8'h70));
    pulse_fs();
    check_eq("oob_fs_clr", 128'(err_oob), 128'(0));
    do_req(200, 1, lat);
    check_eq("oob_req_top", cap_top, fill(8'h7f));
    check_eq("oob_req_err", 128'(err_oob), 128'(1));

    // Sequence check
    pulse_fs();
    do_req(3, 2, lat);
    do_upd(4, 2, mk_rec_row(8'h00), lat);
    check_eq("seq_set", 128'(seq_err), 128'(SeqEn));
    pulse_fs();
    check_eq("seq_clr", 128'(seq_err), 128'(0));

    // Asynchronous reset while ack is showing
    req_x = 0; req_y = 0; req = 1'b1;
    step();
    step();
    check_eq("ar_ack_pre", 128'(ack), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_ack", 128'(ack), 128'(0));
    check_eq("ar_busy", 128'(busy), 128'(0));
    check_eq("ar_top", top, 128'(0));
    check_eq("ar_left", left, 128'(0));
    check_eq("ar_tl", 128'(top_left), 128'(0));
    req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intra_nb_ctx.md
Name: intra_nb_ctx

Overview:
- Neighbour-context stage placed directly upstream of the intra-16x16 mode picker.
- For each macroblock (x,y) it supplies the prediction context: top row (16 px), left column (16 px) and top_left pixel. Unavailable neighbours are filled with the standard VP8 edge defaults.
- After the picker returns the chosen reconstruction, the block stores that MB's bottom row in a line buffer and its right column in a left register, ready for the next MB.

Parameters:
- BLOCK_SIZE, 16, macroblock edge in pixels.
- MAX_MB_W, 128, line-buffer depth in macroblocks (maximum frame width in MBs).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse; clears the context at the start of a frame
- req  in  1  context request; level, held until ack
- req_x  in  10  MB column of the request
- req_y  in  10  MB row of the request
- ack  out  1  one-cycle pulse; top/left/top_left valid from this cycle until the next req
- top  out  8*BLOCK_SIZE  top-neighbour row, pixel 0 in bits [7:0]
- left  out  8*BLOCK_SIZE  left-neighbour column, row 0 in bits [7:0]
- top_left  out  8  corner pixel
- upd  in  1  reconstruction update; level, held until upd_ack
- upd_x  in  10  MB column of the update
- upd_y  in  10  MB row of the update (used only by the optional check)
- rec  in  8*BLOCK_SIZE*BLOCK_SIZE  reconstructed MB, raster order, pixel (r,c) at byte r*16+c
- upd_ack  out  1  one-cycle pulse; update committed
- busy  out  1  high in every state except IDLE
- err_oob  out  1  sticky; set by any x >= MAX_MB_W
- seq_err  out  1  sticky sequence error (optional feature)

Behaviour:
- Reset values: all outputs 0; top/left/top_left registers 0; state IDLE. Line-buffer contents are undefined after reset and are never read before being written in the same frame (defaults cover row 0).
- Line buffer: MAX_MB_W entries x 128 bits, one synchronous read port and one write port, 1-cycle read latency.
- Left register: 128 bits. tl register: 8 bits.
- States: IDLE, RD, RSP, WR.
- IDLE:
  - upd=1 -> WR. upd has priority when upd and req are both high.
  - else req=1 -> RD; latch req_x/req_y and issue the line-buffer read at req_x.
- RD -> RSP, unconditionally.
- RSP: load the outputs as follows, pulse ack, then -> IDLE.
  - top: 16 x 0x7F if y==0, else the line-buffer data.
  - left: 16 x 0x81 if x==0, else the left register.
  - top_left: 0x7F if y==0; else 0x81 if x==0; else the tl register.
- WR: commit the update, pulse upd_ack, then -> IDLE.
  - Write rec row 15 (bytes 240..255) to line-buffer[upd_x].
  - Left register <= rec column 15 (bytes 15,31,..,255).
  - tl register <= top[127:120], the currently presented top pixel 15, which is the corner for MB x+1.
- Latency: req to ack is 3 cycles (IDLE, RD, RSP); upd to upd_ack is 2 cycles.
- A requester drops req/upd in the cycle after its ack. If it is still high in IDLE, that counts as a new transaction.
- Out-of-range address (x >= MAX_MB_W):
  - On update: the write is suppressed and err_oob is set; upd_ack is still pulsed.
  - On request: top is forced to 16 x 0x7F and err_oob is set.
- frame_start, in any state:
  - state -> IDLE; left/tl registers -> 0; err_oob and seq_err -> 0.
  - Any in-flight ack/upd_ack is suppressed and no line-buffer write occurs that cycle.
  - frame_start wins over a simultaneous upd or req; those are seen the following cycle.
- Asynchronous reset mid-transaction: returns to IDLE immediately with all outputs cleared.
- top/left/top_left hold their values between acks. The picker samples them on ack.

Optional Feature:
- Macro: NB_SEQ_CHECK_EN.
- When defined, the block keeps the (x,y) of the last acked request.
  - An update whose (upd_x, upd_y) differs from it sets seq_err (sticky until frame_start or reset).
  - So does a second request with no update in between.
  - The update itself is still committed.
- When undefined, seq_err is tied to 0 and no tracking registers exist.

Test Plan:
- Corner MB: reset, frame_start, req (0,0) -> ack on the 3rd cycle; top = 16 x 0x7F, left = 16 x 0x81, top_left = 0x7F.
- Left register and corner: upd (0,0) with rec pixel = r*16+c; then req (1,0).
  - Expect left bytes = 15,31,..,255.
  - Expect top = 0x7F x 16 and top_left = 0x7F.
- Line buffer and corner: complete row 0 for x=0..2 (rec pixel = 0x10*x + c). Then:
  - req (0,1) -> top = row 15 of MB0, left = 0x81 x 16, top_left = 0x81.
  - upd (0,1), then req (1,1) -> top_left = MB0 row-15 pixel 15.
- Priority: upd and req asserted in the same cycle -> upd_ack 2 cycles later; ack 3 cycles after upd_ack; the returned context reflects the update.
- Abort and out-of-range: frame_start in RD -> no ack, busy low next cycle. upd_x = 200 -> upd_ack pulses, err_oob = 1, the line buffer is unchanged.
- With NB_SEQ_CHECK_EN: req (3,2) then upd (4,2) -> seq_err = 1; frame_start -> seq_err = 0.
